// File: rtl/dii_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dii_channel_arbiter
// Purpose  : N-to-1 packet arbiter for DII flit channels. One input is granted
//            for a whole packet (first flit through the flit marked last);
//            round-robin rotation follows each completed packet. Flits leave
//            through a single registered output stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_data    N*WIDTH flit data, channel i at [i*WIDTH +: WIDTH]
//   in_first   per-channel first-flit marker (forwarded only)
//   in_last    per-channel last-flit marker (ends the packet lock)
//   in_valid   per-channel flit valid
//   in_ready   per-channel accept (combinational, at most one high)
//   out_data   registered flit data
//   out_first  registered first marker
//   out_last   registered last marker
//   out_valid  registered valid
//   out_ready  downstream ready
//   grant      channel currently or last granted
//   locked     packet in progress
// ============================================================================
module dii_channel_arbiter #(
  parameter int N     = 2,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N*WIDTH-1:0]           in_data,
  input  logic [N-1:0]                 in_first,
  input  logic [N-1:0]                 in_last,
  input  logic [N-1:0]                 in_valid,
  output logic [N-1:0]                 in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N)-1:0]         grant,
  output logic                         locked
);

  localparam int GW = $clog2(N);

  logic [GW-1:0]    rr_q, grant_q;
  logic             locked_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_first_q, out_last_q, out_valid_q;

  logic             load;
  logic [GW-1:0]    sel;
  logic             sel_valid;
  logic             xfer;
  logic [GW-1:0]    rr_d;

  // Output register accepts a new flit when empty or being drained.
  assign load = !out_valid_q | out_ready;
  assign xfer = load & sel_valid;

  // Channel selection. While idle, scan rr, rr+1, ... modulo N; the loop runs
  // from the farthest offset down so the nearest valid channel wins.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    sel       = grant_q;
    sel_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    if (locked_q) begin
      sel       = grant_q;
      sel_valid = in_valid[grant_q];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        sum = {1'b0, rr_q} + (GW+1)'(k);
        if (sum >= (GW+1)'(N)) begin
          sum = sum - (GW+1)'(N);
        end
        idx = sum[GW-1:0];
        if (in_valid[idx]) begin
          sel       = idx;
          sel_valid = 1'b1;
        end
      end
    end
  end

  // in_ready is forced low during reset so no source sees a phantom accept.
  always_comb begin
    in_ready = '0;
    if (!rst && xfer) begin
      in_ready[sel] = 1'b1;
    end
  end

  // Next round-robin start: one past the channel that just finished.
  assign rr_d = (sel == GW'(N - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      grant_q     <= '0;
      locked_q    <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        if (sel_valid) begin
          out_data_q  <= in_data[int'(sel)*WIDTH +: WIDTH];
          out_first_q <= in_first[sel];
          out_last_q  <= in_last[sel];
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (xfer) begin
        grant_q <= sel;
        if (in_last[sel]) begin
          locked_q <= 1'b0;
          rr_q     <= rr_d;
        end else begin
          locked_q <= 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_dii_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dii_channel_arbiter
// Purpose  : Directed self-checking bench for dii_channel_arbiter. A 3-channel
//            instance covers rotation, packet lock, backpressure, gaps and
//            asynchronous reset; a 5-channel instance covers wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dii_channel_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 3-channel instance
  logic [3*W-1:0] in_data;
  logic [2:0]     in_first, in_last, in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_first, out_last, out_valid, out_ready;
  logic [1:0]     grant;
  logic           locked;

  // 5-channel instance
  logic [5*W-1:0] d5_data;
  logic [4:0]     d5_first, d5_last, d5_valid, d5_ready;
  logic [W-1:0]   o5_data;
  logic           o5_first, o5_last, o5_valid, o5_ready;
  logic [2:0]     grant5;
  logic           locked5;

  int checks   = 0;
  int failures = 0;

  dii_channel_arbiter #(.N(3), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .locked(locked)
  );

  dii_channel_arbiter #(.N(5), .WIDTH(W)) dut5 (
    .clk(clk), .rst(rst),
    .in_data(d5_data), .in_first(d5_first), .in_last(d5_last),
    .in_valid(d5_valid), .in_ready(d5_ready),
    .out_data(o5_data), .out_first(o5_first), .out_last(o5_last),
    .out_valid(o5_valid), .out_ready(o5_ready),
    .grant(grant5), .locked(locked5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] d, input logic f,
                        input logic l, input logic v);
    in_data[c*W +: W] = d;
    in_first[c] = f;
    in_last[c]  = l;
    in_valid[c] = v;
  endtask

  task automatic set5(input int c, input logic [W-1:0] d, input logic f,
                      input logic l, input logic v);
    d5_data[c*W +: W] = d;
    d5_first[c] = f;
    d5_last[c]  = l;
    d5_valid[c] = v;
  endtask

  // Ends 3 time units after a rising edge, clear of the next edge.
  task automatic do_reset();
    in_valid  = '0;
    d5_valid  = '0;
    out_ready = 1'b1;
    o5_ready  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    in_data = '0; in_first = '0; in_last = '0;
    d5_data = '0; d5_first = '0; d5_last = '0;
    rst = 1'b1;
    set_ch(0, 16'h1111, 1'b1, 1'b1, 1'b1);
    set_ch(1, 16'h2222, 1'b1, 1'b1, 1'b1);
    out_ready = 1'b1; o5_ready = 1'b1; d5_valid = 5'b11111;
    tick(); tick();
    checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL reset_in_ready act=%b exp=000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data act=%h exp=0000", out_data); end
    checks++; if ({out_first, out_last} !== 2'b00) begin failures++; $display("FAIL reset_markers act=%b exp=00", {out_first, out_last}); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked act=%b exp=0", locked); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_grant act=%0d exp=0", grant); end
    checks++; if (d5_ready !== 5'b00000) begin failures++; $display("FAIL reset_in_ready5 act=%b exp=00000", d5_ready); end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    set_ch(0, 16'h1000, 1'b1, 1'b1, 1'b1);
    set_ch(1, 16'h2000, 1'b1, 1'b1, 1'b1);
    set_ch(2, 16'h3000, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      logic [2:0]   er;
      logic [W-1:0] ed;
      er = 3'(1 << (k % 3));
      ed = 16'(16'h1000 * ((k % 3) + 1));
      #1;
      checks++; if (in_ready !== er) begin failures++; $display("FAIL rr_in_ready k=%0d act=%b exp=%b", k, in_ready, er); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== ed) begin failures++; $display("FAIL rr_out k=%0d act=%b/%h exp=1/%h", k, out_valid, out_data, ed); end
      checks++; if (grant !== 2'(k % 3)) begin failures++; $display("FAIL rr_grant k=%0d act=%0d exp=%0d", k, grant, k % 3); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rr_locked k=%0d act=%b exp=0", k, locked); end
    end
    in_valid = '0;
  endtask

  task automatic test_lock();
    do_reset();
    set_ch(1, 16'h00A1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 3'b010) begin failures++; $display("FAIL lock_a1_ready act=%b exp=010", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00A1 || out_first !== 1'b1) begin failures++; $display("FAIL lock_a1_out act=%h/%b exp=00a1/1", out_data, out_first); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_a1_locked act=%b exp=1", locked); end
    set_ch(0, 16'h00B0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      logic [W-1:0] ed;
      ed = 16'(16'h00A1 + k);
      set_ch(1, ed, 1'b0, (k == 3), 1'b1);
      #1;
      checks++; if (in_ready !== 3'b010) begin failures++; $display("FAIL lock_hold_ready k=%0d act=%b exp=010", k, in_ready); end
      tick();
      checks++; if (out_data !== ed) begin failures++; $display("FAIL lock_out k=%0d act=%h exp=%h", k, out_data, ed); end
      checks++; if (locked !== (k != 3)) begin failures++; $display("FAIL lock_locked k=%0d act=%b exp=%b", k, locked, (k != 3)); end
    end
    in_valid[1] = 1'b0;
    #1;
    checks++; if (in_ready !== 3'b001) begin failures++; $display("FAIL lock_ch0_ready act=%b exp=001", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00B0 || grant !== 2'd0) begin failures++; $display("FAIL lock_ch0_out act=%h/%0d exp=00b0/0", out_data, grant); end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ch(2, 16'h00C1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 3'b100) begin failures++; $display("FAIL bp_c1_ready act=%b exp=100", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00C1) begin failures++; $display("FAIL bp_c1_out act=%h exp=00c1", out_data); end
    set_ch(2, 16'h00C2, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL bp_ready k=%0d act=%b exp=000", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h00C1) begin failures++; $display("FAIL bp_hold k=%0d act=%b/%h exp=1/00c1", k, out_valid, out_data); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL bp_locked k=%0d act=%b exp=1", k, locked); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 3'b100) begin failures++; $display("FAIL bp_resume_ready act=%b exp=100", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00C2) begin failures++; $display("FAIL bp_c2_out act=%h exp=00c2", out_data); end
    set_ch(2, 16'h00C3, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (out_data !== 16'h00C3 || out_last !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL bp_c3_out act=%h/%b/%b exp=00c3/1/0", out_data, out_last, locked); end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h00C3) begin failures++; $display("FAIL bp_drain act=%b/%h exp=0/00c3", out_valid, out_data); end
  endtask

  task automatic test_gap();
    do_reset();
    set_ch(2, 16'h00D1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (out_data !== 16'h00D1 || grant !== 2'd2) begin failures++; $display("FAIL gap_d1 act=%h/%0d exp=00d1/2", out_data, grant); end
    set_ch(0, 16'h00E0, 1'b1, 1'b1, 1'b1);
    set_ch(2, 16'h00D2, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (in_ready !== 3'b100) begin failures++; $display("FAIL gap_d2_ready act=%b exp=100", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00D2) begin failures++; $display("FAIL gap_d2_out act=%h exp=00d2", out_data); end
    in_valid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL gap_ready k=%0d act=%b exp=000", k, in_ready); end
      tick();
      checks++; if (grant !== 2'd2 || locked !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL gap_hold k=%0d act=%0d/%b/%b exp=2/1/0", k, grant, locked, out_valid); end
    end
    set_ch(2, 16'h00D3, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 3'b100) begin failures++; $display("FAIL gap_d3_ready act=%b exp=100", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00D3 || locked !== 1'b0) begin failures++; $display("FAIL gap_d3_out act=%h/%b exp=00d3/0", out_data, locked); end
    in_valid[2] = 1'b0;
    #1;
    checks++; if (in_ready !== 3'b001) begin failures++; $display("FAIL gap_ch0_ready act=%b exp=001", in_ready); end
    tick();
    checks++; if (out_data !== 16'h00E0 || grant !== 2'd0) begin failures++; $display("FAIL gap_ch0_out act=%h/%0d exp=00e0/0", out_data, grant); end
    in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ch(1, 16'h00F1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (locked !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre act=%b/%b exp=1/1", locked, out_valid); end
    set_ch(1, 16'h00F2, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL ar_drop act=%b/%b exp=0/0", out_valid, locked); end
    checks++; if (in_ready !== 3'b000) begin failures++; $display("FAIL ar_in_ready act=%b exp=000", in_ready); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL ar_out_data act=%h exp=0000", out_data); end
    tick();
    #2;
    rst = 1'b0;
    set_ch(2, 16'h00F9, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 3'b010) begin failures++; $display("FAIL ar_first_ready act=%b exp=010", in_ready); end
    tick();
    checks++; if (grant !== 2'd1 || out_data !== 16'h00F2 || locked !== 1'b1) begin failures++; $display("FAIL ar_first_grant act=%0d/%h/%b exp=1/00f2/1", grant, out_data, locked); end
    in_valid = '0;
  endtask

  task automatic test_wrap5();
    do_reset();
    set5(3, 16'h0300, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (d5_ready !== 5'b01000) begin failures++; $display("FAIL w5_pre_ready act=%b exp=01000", d5_ready); end
    tick();
    checks++; if (grant5 !== 3'd3 || o5_data !== 16'h0300) begin failures++; $display("FAIL w5_pre_out act=%0d/%h exp=3/0300", grant5, o5_data); end
    set5(3, 16'h0333, 1'b1, 1'b1, 1'b1);
    set5(1, 16'h0111, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (d5_ready !== 5'b00010) begin failures++; $display("FAIL w5_ch1_ready act=%b exp=00010", d5_ready); end
    tick();
    checks++; if (grant5 !== 3'd1 || o5_data !== 16'h0111) begin failures++; $display("FAIL w5_ch1_out act=%0d/%h exp=1/0111", grant5, o5_data); end
    #1;
    checks++; if (d5_ready !== 5'b01000) begin failures++; $display("FAIL w5_ch3_ready act=%b exp=01000", d5_ready); end
    tick();
    checks++; if (grant5 !== 3'd3 || o5_data !== 16'h0333) begin failures++; $display("FAIL w5_ch3_out act=%0d/%h exp=3/0333", grant5, o5_data); end
    d5_valid = '0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_gap();
    test_async_reset();
    test_wrap5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dii_channel_arbiter.md
Name: dii_channel_arbiter

Overview:
- Parametrised N-to-1 packet arbiter for DII flit channels: WIDTH-bit data plus first/last/valid/ready per channel.
- Grants one input for a whole packet, from first flit through last flit, then rotates round-robin.
- Forwards flits through a registered output stage.
- Sits between debug modules and a ring/router ingress port where several DII sources share one link.

Parameters:
- N, 2, number of input channels (≥2).
- WIDTH, 16, flit data width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_data  input  N*WIDTH  flit data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_first  input  N  first-flit marker per channel.
- in_last  input  N  last-flit marker per channel.
- in_valid  input  N  flit valid per channel.
- in_ready  output  N  flit accepted per channel (combinational).
- out_data  output  WIDTH  registered flit data.
- out_first  output  1  registered first marker.
- out_last  output  1  registered last marker.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- grant  output  $clog2(N)  channel currently or last granted (debug/observability).
- locked  output  1  packet in progress; set after a non-last flit is accepted.

Behaviour:
- Reset (async, asserted while rst=1):
  - out_valid=0; out_data=0; out_first=0; out_last=0.
  - locked=0; grant=0; round-robin pointer rr=0.
  - in_ready=0 for all channels while rst is asserted.
- Output register:
  - Loads when `load = !out_valid | out_ready`.
  - On load with an accepted flit: out_* take that flit and out_valid=1.
  - On load with no flit: out_valid=0; out_data and markers hold.
  - Latency is 1 cycle from input acceptance to out_valid.
  - Throughput is 1 flit/cycle when out_ready stays high.
- Handshakes:
  - A transfer occurs on a channel when in_valid & in_ready.
  - Downstream transfer occurs when out_valid & out_ready.
  - in_ready[i] = load & (sel == i) & sel_valid. At most one in_ready is high per cycle.
- Arbitration, IDLE (locked=0):
  - sel = first channel with in_valid set, scanning rr, rr+1, … modulo N.
  - sel_valid = any in_valid.
  - The selected flit transfers in the same cycle it is chosen, with no extra arbitration cycle.
  - grant <= sel on any transfer.
  - Transferred flit has last=0: locked <= 1.
  - Transferred flit has last=1 (single-flit packet): stay IDLE, rr <= (sel+1) mod N.
- LOCKED (locked=1):
  - sel = grant; sel_valid = in_valid[grant]. All other channels get in_ready=0 regardless of their valid.
  - On transfer of a flit with last=1: locked <= 0, rr <= (grant+1) mod N.
  - Gaps (in_valid[grant]=0) keep the lock; there is no timeout.
- first marker:
  - Forwarded unchanged and not used for arbitration. The packet boundary is defined solely by last.
- Wrap-around:
  - rr from N-1 wraps to 0.
  - For non-power-of-2 N, the scan and increment are modulo N, never reaching unused index values.
- Backpressure:
  - out_valid=1 & out_ready=0 → all in_ready=0.
  - Output register, lock and rr all hold.
- Simultaneous events:
  - Downstream pop and upstream accept in the same cycle are both honoured (load=1 via out_ready).
  - Last flit of channel A accepted in cycle t: channel B may be granted in t+1, but not in t.
- Input stability: the arbiter does not require in_data to be stable while in_valid=1 & in_ready=0 (DII sources hold them anyway).
- Reset mid-packet:
  - Lock and the in-flight output flit are discarded.
  - After release, arbitration restarts from rr=0. A partial packet upstream is then seen as a new packet.

Test Plan:
- N=3, WIDTH=16. Channels 0, 1, 2 each present a 1-flit packet (first=last=1) continuously, out_ready=1 → output order ch0, ch1, ch2, ch0…. One flit per cycle; data 0x1000, 0x2000, 0x3000 in sequence.
- Ch1 sends a 4-flit packet 0xA1..0xA4 while ch0 has valid asserted throughout.
  - ch0 in_ready stays 0 until 0xA4 is accepted.
  - Ch0's flit appears on out_data the cycle after ch0's acceptance, which follows 0xA4's acceptance.
  - locked=1 for the 3 cycles after 0xA1, 0xA2, 0xA3 are accepted.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_valid stays 1 with data stable. All in_ready=0. No flit is lost or duplicated after out_ready returns to 1.
- Gap inside a locked packet: ch2 drops valid for 3 cycles between flits 2 and 3 while ch0 is valid → grant stays 2 and ch0 is not serviced until ch2's last flit.
- Reset asserted asynchronously mid-packet (between clock edges) → out_valid, locked and in_ready drop immediately. After release, the first grant goes to the lowest-index valid channel.
- N=5 wrap-around: rr=4 with channels 1 and 3 valid → ch1 is granted first, then ch3.
